pipeline_elastic_stage: RTL and testbench
=========================================

// Module: pipeline_elastic_stage
// PURPOSE
//  Parametrised pipeline stage register that replaces per-field stall-driven flops between stages.
//  - Two-entry elastic buffer (main + skid) with valid/ready handshakes on both sides.
//  - Synchronous flush for squashing the stage.
//  - "Late" lane for data that arrives one cycle after its entry is accepted (e.g. RAM read data).
//  Sits between any two pipeline stages (EX/MEM, MEM/WB, ...) and gives full throughput with a
//  registered in_ready.
// PARAMETERS
//  DATA_WIDTH   32   width of the early payload (flags, result, reg addr, pc), captured at accept
//  LATE_WIDTH   32   width of the late payload, sampled in the cycle after accept; minimum 1
//  RESET_DATA   0    value loaded into the data registers of both slots on reset and on flush
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           asynchronous reset, active-high
//  flush      in   1           discard all held entries at the next edge
//  in_valid   in   1           upstream offers in_data
//  in_ready   out  1           stage can accept; registered, == !skid_valid
//  in_data    in   DATA_WIDTH  early payload
//  late_in    in   LATE_WIDTH  late payload for the entry accepted at the previous edge
//  out_valid  out  1           main slot holds an entry
//  out_ready  in   1           downstream accepts out_data/late_out
//  out_data   out  DATA_WIDTH  early payload of head entry (registered)
//  late_out   out  LATE_WIDTH  late payload of head entry (late_in while fresh, else registered)
//  count      out  2           entries held (0..2)
// BEHAVIOUR
//  Reset (async, rst=1):
//   - valid flags of both slots = 0; out_valid=0, in_ready=1, count=0.
//   - Data regs = RESET_DATA; late regs = 0; fresh flags = 0.
//  Handshakes:
//   - accept = in_valid & in_ready; pop = out_valid & out_ready.
//   - in_ready depends only on state, never combinationally on out_ready.
//   - Upstream holds in_data while in_valid & !in_ready.
//   - Downstream sees stable out_data while out_valid & !out_ready.
//  Slot update at each edge (no flush):
//   - main empty, or main popped with skid empty: accepted entry -> main.
//   - main held (not popped), skid empty: accepted entry -> skid; in_ready drops next cycle.
//   - main popped, skid valid: skid -> main; accept impossible (in_ready=0); skid empties.
//   - Accept and pop in the same cycle with one entry: count stays 1 (pass-through, no bubble).
//  Latency and throughput:
//   - Latency in_valid->out_valid = 1 cycle.
//   - Sustained rate 1 entry/cycle when out_ready=1.
//   - With out_ready low the stage absorbs 2 entries, then stalls upstream.
//  Late lane:
//   - A slot written at accept edge t is marked fresh during cycle t+1.
//   - While fresh, that slot's late value is late_in, and late_out = late_in if the slot is main.
//   - At edge t+1, late_in is latched into the slot's late reg and fresh clears.
//   - If the fresh entry moves skid->main at that edge, the latched value moves with it.
//   - A fresh entry popped in cycle t+1 delivers late_in combinationally; no capture needed.
//   - late_in is don't-care in cycles not following an accept.
//  Flush:
//   - Both valids and fresh flags clear at the next edge; data regs <= RESET_DATA.
//   - An accept in the flush cycle is discarded; a pop in the flush cycle still completes.
//   - in_ready = 1 in the cycle after flush.
//   - Flush has priority over all other updates.
//  count = main_valid + skid_valid; never exceeds 2; count==2 exactly when in_ready==0.
//  Reset mid-operation: all state cleared immediately; in-flight and late data are lost.
// TESTING
//  1 Reset: assert rst mid-stream with count=2 -> same cycle out_valid=0, count=0, in_ready=1,
//    out_data=RESET_DATA.
//  2 Streaming: out_ready=1, in_data=1,2,3 on consecutive cycles, late_in=A,B,C one cycle later ->
//    out_data 1,2,3 one cycle after each accept, late_out A,B,C, no bubbles.
//  3 Backpressure: out_ready=0, offer 5,6,7 ->
//    - 5 and 6 accepted, in_ready=0 after the second, count=2, 7 held upstream.
//    - Raise out_ready: pops 5 then 6 with their late values; 7 accepted once in_ready=1.
//  4 Fresh move: out_ready=0 with main=5, accept 6 into skid, late_in=0xBEEF next cycle, then
//    out_ready=1 -> after 5 pops, out_data=6 and late_out=0xBEEF.
//  5 Flush: count=2 with in_valid=1 and flush=1 ->
//    - Next cycle count=0, out_valid=0, in_ready=1.
//    - The offered entry is not seen at the output.
//  6 Simultaneous accept+pop with count=1 over 100 random cycles -> count never 0 or 2 in between;
//    order and late pairing match a scoreboard.

Source files
------------

// File: rtl/pipeline_elastic_stage_if.sv
// One valid/ready link carrying an early payload and a late payload that trails it by a cycle.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface pipeline_elastic_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LATE_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [LATE_WIDTH-1:0] late;

  modport master (output valid, output data, output late, input  ready);
  modport slave  (input  valid, input  data, input  late, output ready);
endinterface

// File: rtl/pipeline_elastic_stage.sv
// Two-entry elastic pipeline register (main + skid) with a registered in_ready, synchronous flush
// and a late lane whose payload arrives one cycle after its entry is accepted.
module pipeline_elastic_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    LATE_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  pipeline_elastic_stage_if.slave          in_bus,
  pipeline_elastic_stage_if.master         out_bus,
  output logic [1:0]                       count
);

  logic                  r_main_valid, r_skid_valid;
  logic                  r_main_fresh, r_skid_fresh;
  logic [DATA_WIDTH-1:0] r_main_data,  r_skid_data;
  logic [LATE_WIDTH-1:0] r_main_late,  r_skid_late;

  logic                  w_main_valid_d, w_skid_valid_d;
  logic                  w_main_fresh_d, w_skid_fresh_d;
  logic [DATA_WIDTH-1:0] w_main_data_d,  w_skid_data_d;
  logic [LATE_WIDTH-1:0] w_main_late_d,  w_skid_late_d;

  logic                  w_accept, w_pop;
  logic [LATE_WIDTH-1:0] w_main_late, w_skid_late;

  assign w_accept = in_bus.valid & ~r_skid_valid;
  assign w_pop    = r_main_valid & out_bus.ready;

  // A slot written at the previous edge takes its late value straight from the late lane.
  assign w_main_late = r_main_fresh ? in_bus.late : r_main_late;
  assign w_skid_late = r_skid_fresh ? in_bus.late : r_skid_late;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    w_main_valid_d = r_main_valid;
    w_skid_valid_d = r_skid_valid;
    w_main_data_d  = r_main_data;
    w_skid_data_d  = r_skid_data;
    w_main_late_d  = w_main_late;
    w_skid_late_d  = w_skid_late;
    w_main_fresh_d = 1'b0;
    w_skid_fresh_d = 1'b0;

    if (flush) begin
      w_main_valid_d = 1'b0;
      w_skid_valid_d = 1'b0;
      w_main_data_d  = RESET_DATA;
      w_skid_data_d  = RESET_DATA;
    end else if (!r_main_valid || (w_pop && !r_skid_valid)) begin
      w_main_valid_d = w_accept;
      if (w_accept) begin
        w_main_data_d  = in_bus.data;
        w_main_fresh_d = 1'b1;
      end
    end else if (!w_pop) begin
      // Main is held; a new entry lands in skid and in_ready drops next cycle.
      if (w_accept) begin
        w_skid_valid_d = 1'b1;
        w_skid_data_d  = in_bus.data;
        w_skid_fresh_d = 1'b1;
      end
    end else begin
      w_main_data_d  = r_skid_data;
      w_main_late_d  = w_skid_late;
      w_skid_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_fresh <= 1'b0;
      r_skid_fresh <= 1'b0;
      r_main_data  <= RESET_DATA;
      r_skid_data  <= RESET_DATA;
      r_main_late  <= '0;
      r_skid_late  <= '0;
    end else begin
      r_main_valid <= w_main_valid_d;
      r_skid_valid <= w_skid_valid_d;
      r_main_fresh <= w_main_fresh_d;
      r_skid_fresh <= w_skid_fresh_d;
      r_main_data  <= w_main_data_d;
      r_skid_data  <= w_skid_data_d;
      r_main_late  <= w_main_late_d;
      r_skid_late  <= w_skid_late_d;
    end
  end

  assign in_bus.ready  = ~r_skid_valid;
  assign out_bus.valid = r_main_valid;
  assign out_bus.data  = r_main_data;
  assign out_bus.late  = w_main_late;
  assign count         = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

endmodule

// File: tb/tb_pipeline_elastic_stage.sv
// Bench for pipeline_elastic_stage: directed vector table, mid-stream reset, and random traffic
// compared against a queue model of the stage.
module tb_pipeline_elastic_stage;

  localparam int                DW = 32;
  localparam int                LW = 16;
  localparam logic [DW-1:0]     RD = 32'hDEAD_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [1:0]    count;

  pipeline_elastic_stage_if #(.DATA_WIDTH(DW), .LATE_WIDTH(LW)) in_bus ();
  pipeline_elastic_stage_if #(.DATA_WIDTH(DW), .LATE_WIDTH(LW)) out_bus ();

  pipeline_elastic_stage #(.DATA_WIDTH(DW), .LATE_WIDTH(LW), .RESET_DATA(RD)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .in_bus  (in_bus),
    .out_bus (out_bus),
    .count   (count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [DW-1:0] d,
                       input logic [LW-1:0] lt, input logic ordy);
    flush          = fl;
    in_bus.valid   = iv;
    in_bus.data    = d;
    in_bus.late    = lt;
    out_bus.ready  = ordy;
  endtask

  typedef struct {
    logic          fl, iv;
    logic [DW-1:0] d;
    logic [LW-1:0] lt;
    logic          ordy;
    logic          ov, ir;
    logic [1:0]    cnt;
    logic [DW-1:0] od;
    logic [LW-1:0] lo;
    logic          chk_od, chk_lo;
  } vec_t;

  function automatic vec_t mk(logic fl, logic iv, logic [DW-1:0] d, logic [LW-1:0] lt, logic ordy,
                              logic ov, logic ir, logic [1:0] cnt, logic [DW-1:0] od,
                              logic [LW-1:0] lo, logic chk_od, logic chk_lo);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.lt = lt; v.ordy = ordy;
    v.ov = ov; v.ir = ir; v.cnt = cnt; v.od = od; v.lo = lo;
    v.chk_od = chk_od; v.chk_lo = chk_lo;
    return v;
  endfunction

  // Reference model: an ordered list of held entries; a pending entry's late value is whatever
  // the late lane carries in the cycle after its acceptance.
  typedef struct {
    logic [DW-1:0] d;
    logic [LW-1:0] lt;
    bit            pend;
  } ent_t;

  ent_t q[$];

  task automatic model_cycle(input logic fl, input logic iv, input logic [DW-1:0] d,
                             input logic [LW-1:0] lt, input logic ordy, input string tag);
    bit acc, pop;
    logic [LW-1:0] exp_lo;
    drive(fl, iv, d, lt, ordy);
    #2;
    check({tag, ".count"},     64'(count),        64'(q.size()));
    check({tag, ".in_ready"},  64'(in_bus.ready), 64'(q.size() < 2));
    check({tag, ".out_valid"}, 64'(out_bus.valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      exp_lo = q[0].pend ? lt : q[0].lt;
      check({tag, ".out_data"}, 64'(out_bus.data), 64'(q[0].d));
      check({tag, ".late_out"}, 64'(out_bus.late), 64'(exp_lo));
    end
    acc = iv && (q.size() < 2);
    pop = (q.size() > 0) && ordy;
    @(posedge clk);
    foreach (q[i]) if (q[i].pend) begin q[i].lt = lt; q[i].pend = 1'b0; end
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{d: d, lt: '0, pend: 1'b1});
    end
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    rst = 1'b1;
    drive(0, 0, '0, '0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset.count",     64'(count),         64'(0));
    check("reset.in_ready",  64'(in_bus.ready),  64'(1));
    check("reset.out_valid", 64'(out_bus.valid), 64'(0));
    rst = 1'b0;

    //                fl iv d        late      or   ov ir cnt od       lo        cod clo
    vecs.push_back(mk(0, 1, 32'h1,  16'h0,    1,   0, 1, 0, RD,      16'h0,    1,  0)); // streaming
    vecs.push_back(mk(0, 1, 32'h2,  16'h00A,  1,   1, 1, 1, 32'h1,   16'h00A,  1,  1));
    vecs.push_back(mk(0, 1, 32'h3,  16'h00B,  1,   1, 1, 1, 32'h2,   16'h00B,  1,  1));
    vecs.push_back(mk(0, 0, 32'h0,  16'h00C,  1,   1, 1, 1, 32'h3,   16'h00C,  1,  1));
    vecs.push_back(mk(0, 0, 32'h0,  16'h0,    1,   0, 1, 0, 32'h0,   16'h0,    0,  0));
    vecs.push_back(mk(0, 1, 32'h5,  16'h0,    0,   0, 1, 0, 32'h0,   16'h0,    0,  0)); // backpressure
    vecs.push_back(mk(0, 1, 32'h6,  16'h055,  0,   1, 1, 1, 32'h5,   16'h055,  1,  1));
    vecs.push_back(mk(0, 1, 32'h7,  16'h066,  0,   1, 0, 2, 32'h5,   16'h055,  1,  1));
    vecs.push_back(mk(0, 1, 32'h7,  16'h099,  1,   1, 0, 2, 32'h5,   16'h055,  1,  1));
    vecs.push_back(mk(0, 1, 32'h7,  16'h099,  1,   1, 1, 1, 32'h6,   16'h066,  1,  1));
    vecs.push_back(mk(0, 0, 32'h0,  16'h077,  1,   1, 1, 1, 32'h7,   16'h077,  1,  1));
    vecs.push_back(mk(0, 0, 32'h0,  16'h0,    0,   0, 1, 0, 32'h0,   16'h0,    0,  0));
    vecs.push_back(mk(0, 1, 32'h5,  16'h0,    0,   0, 1, 0, 32'h0,   16'h0,    0,  0)); // fresh move
    vecs.push_back(mk(0, 1, 32'h6,  16'h1111, 0,   1, 1, 1, 32'h5,   16'h1111, 1,  1));
    vecs.push_back(mk(0, 0, 32'h0,  16'hBEEF, 1,   1, 0, 2, 32'h5,   16'h1111, 1,  1));
    vecs.push_back(mk(0, 0, 32'h0,  16'h0,    0,   1, 1, 1, 32'h6,   16'hBEEF, 1,  1));
    vecs.push_back(mk(0, 1, 32'h70, 16'h0,    0,   1, 1, 1, 32'h6,   16'hBEEF, 1,  1)); // flush
    vecs.push_back(mk(1, 1, 32'h71, 16'h2,    0,   1, 0, 2, 32'h6,   16'hBEEF, 1,  1));
    vecs.push_back(mk(0, 1, 32'h72, 16'h0,    0,   0, 1, 0, RD,      16'h0,    1,  0));
    vecs.push_back(mk(0, 0, 32'h0,  16'h3,    0,   1, 1, 1, 32'h72,  16'h3,    1,  1));
    vecs.push_back(mk(1, 1, 32'h80, 16'h0,    1,   1, 1, 1, 32'h72,  16'h3,    1,  1));
    vecs.push_back(mk(0, 0, 32'h0,  16'h0,    1,   0, 1, 0, RD,      16'h0,    1,  0));

    foreach (vecs[i]) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].lt, vecs[i].ordy);
      #2;
      check($sformatf("vec%0d.out_valid", i), 64'(out_bus.valid), 64'(vecs[i].ov));
      check($sformatf("vec%0d.in_ready", i),  64'(in_bus.ready),  64'(vecs[i].ir));
      check($sformatf("vec%0d.count", i),     64'(count),         64'(vecs[i].cnt));
      if (vecs[i].chk_od) check($sformatf("vec%0d.out_data", i), 64'(out_bus.data), 64'(vecs[i].od));
      if (vecs[i].chk_lo) check($sformatf("vec%0d.late_out", i), 64'(out_bus.late), 64'(vecs[i].lo));
      @(posedge clk);
      #1;
    end

    // Asynchronous reset with two entries held.
    drive(0, 1, 32'hA1, 16'h0, 0);
    @(posedge clk); #1;
    drive(0, 1, 32'hA2, 16'h5, 0);
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 16'h6, 0);
    #2;
    check("midrst.count_before", 64'(count), 64'(2));
    rst = 1'b1;
    #1;
    check("midrst.out_valid", 64'(out_bus.valid), 64'(0));
    check("midrst.count",     64'(count),         64'(0));
    check("midrst.in_ready",  64'(in_bus.ready),  64'(1));
    check("midrst.out_data",  64'(out_bus.data),  64'(RD));
    check("midrst.late_out",  64'(out_bus.late),  64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();

    // Random traffic including flushes.
    for (int i = 0; i < 400; i++) begin
      model_cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), $urandom,
                  LW'($urandom), ($urandom_range(0, 2) != 0), "rand");
    end

    // Continuous accept+pop: occupancy must settle at exactly one entry.
    model_cycle(1, 0, '0, '0, 1, "passflush");
    for (int i = 0; i < 100; i++) begin
      model_cycle(0, 1, $urandom, LW'($urandom), 1, "pass");
      if (i > 0) check("pass.count_one", 64'(count), 64'(1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
